// File: rtl/freq_to_ctrl_if.sv
// Bus between the digit-entry front end and the frequency-to-control-word
// converter. The front end (master) drives the request and the BCD digits;
// the converter (slave) returns status, results and its FSM state for
// debug visibility.
//
// Handshake: start is a level sampled on a rising edge only while the
// converter is idle (busy=0); the request is accepted on that edge, the
// digits are captured then and may change afterwards. Completion is a
// one-cycle done pulse; there is no back-pressure and no queuing.
interface freq_to_ctrl_if;
  logic        start;
  logic [3:0]  thou_in;
  logic [3:0]  hund_in;
  logic [3:0]  ten_in;
  logic [3:0]  one_in;
  logic        busy;
  logic        done;
  logic        err;
  logic        sat;
  logic [13:0] freq_bin;
  logic [7:0]  ctrl;
  logic [1:0]  state_dbg;

  modport master (
    output start, thou_in, hund_in, ten_in, one_in,
    input  busy, done, err, sat, freq_bin, ctrl, state_dbg
  );

  modport slave (
    input  start, thou_in, hund_in, ten_in, one_in,
    output busy, done, err, sat, freq_bin, ctrl, state_dbg
  );
endinterface

// File: rtl/freq_to_ctrl.sv
// freq_to_ctrl: converts a four-digit BCD target frequency into the 8-bit
// DDS frequency control word K = f * 256 / F_CLK.
// Sequence: IDLE -> BCD (4 cycles, accumulate digits MSD first)
//           -> DIV (22 cycles, restoring division) -> FIN (1 cycle).
// Fixed latency of 27 cycles from the accepting edge to the result edge.
// Optional feature macro: ROUND_NEAREST_EN -- when defined, F_CLK/2 is
// added to the dividend so K rounds to nearest (half up); otherwise K is
// truncated, matching the floor of the theoretical-frequency readout.
module freq_to_ctrl #(
  parameter int F_CLK = 10000
) (
  input logic           clk,
  input logic           rst_n,
  freq_to_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BCD  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [13:0] DIVISOR  = 14'(F_CLK);
  localparam logic [4:0]  DIV_LAST = 5'd21;
`ifdef ROUND_NEAREST_EN
  localparam logic [21:0] ROUND_ADD = 22'(F_CLK / 2);
`else
  localparam logic [21:0] ROUND_ADD = 22'd0;
`endif

  state_t      state;
  logic [1:0]  step;
  logic [4:0]  cnt;
  logic [3:0]  d_thou;
  logic [3:0]  d_hund;
  logic [3:0]  d_ten;
  logic [3:0]  d_one;
  logic [13:0] acc;
  logic [13:0] rem;
  // Dividend bits shift out of the top while quotient bits shift in at
  // the bottom; after 22 steps this register holds the quotient.
  logic [21:0] quo;

  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        sat_r;
  logic [13:0] freq_r;
  logic [7:0]  ctrl_r;

  logic        bad_digit;
  logic [3:0]  cur_digit;
  logic [13:0] acc_next;
  logic [21:0] dividend;
  logic [14:0] shifted;
  logic [15:0] diff;
  logic [13:0] rem_next;
  logic [21:0] quo_next;

  // Request validation on the live inputs: any digit above 9 is rejected.
  always_comb begin
    bad_digit = (bus.thou_in > 4'd9) || (bus.hund_in > 4'd9) ||
                (bus.ten_in  > 4'd9) || (bus.one_in  > 4'd9);
  end

  // BCD accumulate step: pick the digit for this step, thousands first.
  always_comb begin
    cur_digit = d_thou;
    case (step)
      2'd0:    cur_digit = d_thou;
      2'd1:    cur_digit = d_hund;
      2'd2:    cur_digit = d_ten;
      default: cur_digit = d_one;
    endcase
    acc_next = (acc * 14'd10) + {10'd0, cur_digit};
    dividend = {acc_next, 8'd0} + ROUND_ADD;
  end

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor if it fits and record the quotient bit.
  always_comb begin
    shifted  = {rem, quo[21]};
    diff     = {1'b0, shifted} - {2'b00, DIVISOR};
    rem_next = shifted[13:0];
    quo_next = {quo[20:0], 1'b0};
    if (!diff[15]) begin
      rem_next = diff[13:0];
      quo_next = {quo[20:0], 1'b1};
    end
  end

  // Conversion FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= 2'd0;
      cnt    <= 5'd0;
      d_thou <= 4'd0;
      d_hund <= 4'd0;
      d_ten  <= 4'd0;
      d_one  <= 4'd0;
      acc    <= 14'd0;
      rem    <= 14'd0;
      quo    <= 22'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      sat_r  <= 1'b0;
      freq_r <= 14'd0;
      ctrl_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            d_thou <= bus.thou_in;
            d_hund <= bus.hund_in;
            d_ten  <= bus.ten_in;
            d_one  <= bus.one_in;
            sat_r  <= 1'b0;
            if (bad_digit) begin
              // Rejected request: report and stay idle, results untouched.
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else begin
              err_r  <= 1'b0;
              busy_r <= 1'b1;
              acc    <= 14'd0;
              step   <= 2'd0;
              state  <= BCD;
            end
          end
        end
        BCD: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            quo   <= dividend;
            rem   <= 14'd0;
            cnt   <= 5'd0;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (cnt == DIV_LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          if (quo > 22'd255) begin
            ctrl_r <= 8'd255;
            sat_r  <= 1'b1;
          end else begin
            ctrl_r <= quo[7:0];
          end
          freq_r <= acc;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.sat       = sat_r;
  assign bus.freq_bin  = freq_r;
  assign bus.ctrl      = ctrl_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_freq_to_ctrl.sv
// Directed bench for freq_to_ctrl with F_CLK = 10000. Expected control
// words are hand-computed for both the truncating and rounding builds.
module tb_freq_to_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  freq_to_ctrl_if bus ();

  freq_to_ctrl #(.F_CLK(10000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ROUND_NEAREST_EN
  localparam logic [7:0] K_1000 = 8'd26;
  localparam logic [7:0] K_9960 = 8'd255;
  localparam logic       S_9999 = 1'b1;
  localparam logic [7:0] K_0039 = 8'd1;
`else
  localparam logic [7:0] K_1000 = 8'd25;
  localparam logic [7:0] K_9960 = 8'd254;
  localparam logic       S_9999 = 1'b0;
  localparam logic [7:0] K_0039 = 8'd0;
`endif

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a request at the current negedge; returns at the negedge after E0.
  task automatic launch(input logic [3:0] t, input logic [3:0] h,
                        input logic [3:0] te, input logic [3:0] o);
    bus.thou_in = t;
    bus.hund_in = h;
    bus.ten_in  = te;
    bus.one_in  = o;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.thou_in = 4'd0;
    bus.hund_in = 4'd0;
    bus.ten_in  = 4'd0;
    bus.one_in  = 4'd0;
  endtask

  // Wait for done, counting edges since E0; bounded.
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic run_conv(input string tag, input logic [3:0] t,
                          input logic [3:0] h, input logic [3:0] te,
                          input logic [3:0] o, input logic [13:0] f,
                          input logic [7:0] k, input logic s);
    int lat;
    launch(t, h, te, o);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(0, lat);
    check({tag, "_lat"}, 32'(lat), 32'd27);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_freq"}, 32'(bus.freq_bin), 32'(f));
    check({tag, "_ctrl"}, 32'(bus.ctrl), 32'(k));
    check({tag, "_sat"}, 32'(bus.sat), 32'(s));
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int lat;
    n_vec       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.thou_in = 4'd0;
    bus.hund_in = 4'd0;
    bus.ten_in  = 4'd0;
    bus.one_in  = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_freq", 32'(bus.freq_bin), 32'd0);
    check("rst_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv("f1000", 4'd1, 4'd0, 4'd0, 4'd0, 14'd1000, K_1000, 1'b0);
    // back-to-back: start sampled on the edge where done is high
    run_conv("f9960", 4'd9, 4'd9, 4'd6, 4'd0, 14'd9960, K_9960, 1'b0);
    @(negedge clk);
    run_conv("f9999", 4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 8'd255, S_9999);
    @(negedge clk);
    run_conv("f0039", 4'd0, 4'd0, 4'd3, 4'd9, 14'd39, K_0039, 1'b0);
    @(negedge clk);
    run_conv("f5000", 4'd5, 4'd0, 4'd0, 4'd0, 14'd5000, 8'd128, 1'b0);
    @(negedge clk);
    run_conv("f0000", 4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 8'd0, 1'b0);
    @(negedge clk);
    run_conv("f1000b", 4'd1, 4'd0, 4'd0, 4'd0, 14'd1000, K_1000, 1'b0);
    @(negedge clk);

    // invalid digit: immediate err/done, results kept, never busy
    launch(4'd2, 4'hA, 4'd0, 4'd0);
    check("inv_err", 32'(bus.err), 32'd1);
    check("inv_done", 32'(bus.done), 32'd1);
    check("inv_busy", 32'(bus.busy), 32'd0);
    check("inv_ctrl", 32'(bus.ctrl), 32'(K_1000));
    check("inv_freq", 32'(bus.freq_bin), 32'd1000);
    @(negedge clk);
    check("inv_done_off", 32'(bus.done), 32'd0);
    check("inv_err_hold", 32'(bus.err), 32'd1);
    check("inv_busy2", 32'(bus.busy), 32'd0);

    // valid request clears err; second start mid-conversion is ignored
    launch(4'd5, 4'd0, 4'd0, 4'd0);
    check("ign_err_clr", 32'(bus.err), 32'd0);
    repeat (9) @(negedge clk);
    bus.start   = 1'b1;
    bus.thou_in = 4'd9;
    bus.hund_in = 4'd9;
    bus.ten_in  = 4'd9;
    bus.one_in  = 4'd9;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done(10, lat);
    check("ign_lat", 32'(lat), 32'd27);
    check("ign_freq", 32'(bus.freq_bin), 32'd5000);
    check("ign_ctrl", 32'(bus.ctrl), 32'd128);
    @(negedge clk);
    check("ign_no_2nd", 32'(bus.busy), 32'd0);

    // reset mid-conversion: no done, outputs cleared
    launch(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_ctrl", 32'(bus.ctrl), 32'd0);
    check("mid_freq", 32'(bus.freq_bin), 32'd0);
    check("mid_sat", 32'(bus.sat), 32'd0);
    rst_n = 1'b1;
    lat = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) lat++;
    end
    check("mid_no_done", 32'(lat), 32'd0);
    run_conv("post_rst", 4'd0, 4'd0, 4'd3, 4'd9, 14'd39, K_0039, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
